// File: rtl/regfile_exec_ctrl.sv
// Register-file initiator: accepts one register-to-register instruction, reads
// both operands, executes it on an 8-bit ALU, writes back and hands out the result.
module regfile_exec_ctrl #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3+3*AW-1:0] instr,
   output logic              WEN,
   output logic [AW-1:0]     RW,
   output logic [DW-1:0]     busW,
   output logic [AW-1:0]     RX,
   output logic [AW-1:0]     RY,
   input  logic [DW-1:0]     busX,
   input  logic [DW-1:0]     busY,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [2:0]        out_flags
);

   typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LI, OP_SLT
   } op_t;

   state_t        state, stateNext;
   op_t           opReg;
   logic [AW-1:0] rdReg, rsReg, rtReg;
   logic [DW-1:0] aReg, bReg;
   logic [DW-1:0] aluRes;
   logic          aluCarry, aluOvf;

   always_ff @(posedge Clk) begin
      if (!Rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) stateNext = READ;
         end
         READ:  stateNext = EXEC;
         EXEC:  stateNext = WRITE;
         WRITE: stateNext = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      aluRes   = '0;
      aluCarry = 1'b0;
      aluOvf   = 1'b0;
      case (opReg)
         OP_ADD: begin
            {aluCarry, aluRes} = {1'b0, aReg} + {1'b0, bReg};
            aluOvf = (aReg[DW-1] == bReg[DW-1]) && (aluRes[DW-1] != aReg[DW-1]);
         end
         OP_SUB: begin
            // Borrow falls out as the top bit of the widened difference.
            {aluCarry, aluRes} = {1'b0, aReg} - {1'b0, bReg};
            aluOvf = (aReg[DW-1] != bReg[DW-1]) && (aluRes[DW-1] != aReg[DW-1]);
         end
         OP_AND: aluRes = aReg & bReg;
         OP_OR:  aluRes = aReg | bReg;
         OP_XOR: aluRes = aReg ^ bReg;
         OP_MOV: aluRes = aReg;
         OP_LI:  aluRes[2*AW-1:0] = {rsReg, rtReg};
         OP_SLT: aluRes[0] = $signed(aReg) < $signed(bReg);
         default: aluRes = '0;
      endcase
   end

   // Register-file addresses/data are registered so they hold between phases.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         opReg     <= OP_ADD;
         rdReg     <= '0;
         rsReg     <= '0;
         rtReg     <= '0;
         aReg      <= '0;
         bReg      <= '0;
         RX        <= '0;
         RY        <= '0;
         RW        <= '0;
         busW      <= '0;
         WEN       <= 1'b0;
         out_data  <= '0;
         out_flags <= '0;
      end else begin
         WEN <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opReg <= op_t'(instr[3*AW +: 3]);
                  rdReg <= instr[2*AW +: AW];
                  rsReg <= instr[AW +: AW];
                  rtReg <= instr[0 +: AW];
                  RX    <= instr[AW +: AW];
                  RY    <= instr[0 +: AW];
               end
            end
            READ: begin
               aReg <= busX;
               bReg <= busY;
            end
            EXEC: begin
               RW        <= rdReg;
               busW      <= aluRes;
               WEN       <= (rdReg != '0);
               out_data  <= aluRes;
               out_flags <= {(aluRes == '0), aluCarry, aluOvf};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Directed bench for regfile_exec_ctrl with a behavioural 8x8 register file
// (combinational reads, r0 never written) attached to its register ports.
module tb_regfile_exec_ctrl;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] instr;
   logic        WEN;
   logic [2:0]  RW;
   logic [7:0]  busW;
   logic [2:0]  RX;
   logic [2:0]  RY;
   logic [7:0]  busX;
   logic [7:0]  busY;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_flags;

   int total = 0;
   int bad = 0;
   int wenCount = 0;
   int expWen = 0;
   logic [7:0] rf [8] = '{default: '0};
   logic [7:0] expRf [8] = '{default: '0};

   regfile_exec_ctrl #(.DW(8), .AW(3)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .WEN(WEN), .RW(RW), .busW(busW), .RX(RX), .RY(RY),
      .busX(busX), .busY(busY), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_flags(out_flags)
   );

   always #5 Clk = ~Clk;

   assign busX = rf[RX];
   assign busY = rf[RY];

   always @(posedge Clk) begin
      if (WEN && RW != 3'd0) rf[RW] <= busW;
      if (WEN) wenCount <= wenCount + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One instruction at full rate; optional stall cycles in DONE with a stray in_valid.
   task automatic run(input string tag, input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [2:0] rt,
                      input logic [7:0] expData, input logic [2:0] expFlags, input int stall);
      @(negedge Clk);
      chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
      instr    = {op, rd, rs, rt};
      in_valid = 1'b1;
      @(negedge Clk);
      in_valid = 1'b0;
      chk({tag, ".RX"}, 32'(RX), 32'(rs));
      chk({tag, ".RY"}, 32'(RY), 32'(rt));
      chk({tag, ".read_ready"}, 32'(in_ready), 32'd0);
      @(negedge Clk);
      chk({tag, ".exec_wen"}, 32'(WEN), 32'd0);
      @(negedge Clk);
      chk({tag, ".WEN"}, 32'(WEN), 32'(rd != 3'd0));
      chk({tag, ".RW"}, 32'(RW), 32'(rd));
      chk({tag, ".busW"}, 32'(busW), 32'(expData));
      if (stall > 0) out_ready = 1'b0;
      @(negedge Clk);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".out_data"}, 32'(out_data), 32'(expData));
      chk({tag, ".out_flags"}, 32'(out_flags), 32'(expFlags));
      chk({tag, ".done_wen"}, 32'(WEN), 32'd0);
      if (rd != 3'd0) begin
         expRf[rd] = expData;
         expWen++;
      end
      for (int k = 0; k < stall; k++) begin
         in_valid = (k == 3);
         instr    = {3'd6, 3'd7, 3'd7, 3'd7};
         @(negedge Clk);
         chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".stall_data"}, 32'(out_data), 32'(expData));
         chk({tag, ".stall_flags"}, 32'(out_flags), 32'(expFlags));
         chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      Rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = '0;
      repeat (2) @(negedge Clk);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.WEN", 32'(WEN), 32'd0);
      chk("rst.RW", 32'(RW), 32'd0);
      chk("rst.RX", 32'(RX), 32'd0);
      chk("rst.RY", 32'(RY), 32'd0);
      chk("rst.busW", 32'(busW), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data", 32'(out_data), 32'd0);
      chk("rst.out_flags", 32'(out_flags), 32'd0);
      Rst_n = 1'b1;

      // Build r1=0x7F, r2=0x01 (LI reaches at most 0x3F).
      run("li_r1",   3'd6, 3'd1, 3'd7, 3'd7, 8'h3F, 3'b000, 0);
      run("li_r2",   3'd6, 3'd2, 3'd7, 3'd7, 8'h3F, 3'b000, 0);
      run("add_r1a", 3'd0, 3'd1, 3'd1, 3'd2, 8'h7E, 3'b000, 0);
      run("li_r2b",  3'd6, 3'd2, 3'd0, 3'd1, 8'h01, 3'b000, 0);
      run("add_r1b", 3'd0, 3'd1, 3'd1, 3'd2, 8'h7F, 3'b000, 0);
      run("add_ovf", 3'd0, 3'd3, 3'd1, 3'd2, 8'h80, 3'b001, 0);
      run("sub_brw", 3'd1, 3'd4, 3'd2, 3'd1, 8'h82, 3'b010, 0);
      run("sub_zero",3'd1, 3'd5, 3'd1, 3'd1, 8'h00, 3'b100, 0);
      run("mov_r0",  3'd5, 3'd0, 3'd1, 3'd0, 8'h7F, 3'b000, 0);
      run("rd_r0",   3'd5, 3'd6, 3'd0, 3'd0, 8'h00, 3'b100, 0);
      run("and",     3'd2, 3'd6, 3'd3, 3'd1, 8'h00, 3'b100, 0);
      run("or",      3'd3, 3'd6, 3'd3, 3'd1, 8'hFF, 3'b000, 0);
      run("xor_stl", 3'd4, 3'd7, 3'd6, 3'd4, 8'h7D, 3'b000, 10);
      run("slt_t",   3'd7, 3'd7, 3'd3, 3'd1, 8'h01, 3'b000, 0);
      run("slt_f",   3'd7, 3'd5, 3'd1, 3'd3, 8'h00, 3'b100, 0);
      run("add_all", 3'd0, 3'd5, 3'd3, 3'd3, 8'h00, 3'b111, 0);
      run("sub_ovf", 3'd1, 3'd5, 3'd3, 3'd2, 8'h7F, 3'b001, 0);
      chk("wen_count", 32'(wenCount), 32'(expWen));

      // Reset while an ADD to r6 sits in EXEC: nothing may be written.
      @(negedge Clk);
      instr    = {3'd0, 3'd6, 3'd1, 3'd2};
      in_valid = 1'b1;
      @(negedge Clk);
      in_valid = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("abort.WEN", 32'(WEN), 32'd0);
      chk("abort.in_ready", 32'(in_ready), 32'd1);
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      chk("abort.r6", 32'(rf[6]), 32'h0000_00FF);
      chk("abort.wen_count", 32'(wenCount), 32'(expWen));

      run("recover", 3'd0, 3'd6, 3'd1, 3'd2, 8'h80, 3'b001, 0);
      @(negedge Clk);
      chk("final.wen_count", 32'(wenCount), 32'(expWen));
      for (int i = 0; i < 8; i++) chk($sformatf("final.r%0d", i), 32'(rf[i]), 32'(expRf[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_exec_ctrl.md
Name: regfile_exec_ctrl

Overview:
- Initiator side of the 8x8 three-port register file interface. Drives RX/RY, consumes busX/busY, and drives WEN/RW/busW.
- Accepts one register-to-register instruction through a valid/ready handshake. Reads both operands, computes an 8-bit ALU result, writes it back, then reports the result and flags through a valid/ready output handshake.
- Sits between an instruction source (bench or sequencer) and the register file. The register file read path is combinational; its write is on the rising edge of Clk.

Parameters:
- DW, 8, data width; matches the register file bus width.
- AW, 3, register address width; gives 2**AW registers.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  synchronous active-low reset, sampled on the rising edge of Clk.
- in_valid  input  1  instruction valid.
- in_ready  output  1  block can accept an instruction.
- instr  input  3+3*AW  {op[2:0], rd, rs, rt}.
- WEN  output  1  register file write enable.
- RW  output  AW  register file write address.
- busW  output  DW  register file write data.
- RX  output  AW  register file read address X.
- RY  output  AW  register file read address Y.
- busX  input  DW  read data for RX.
- busY  input  DW  read data for RY.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DW  result value.
- out_flags  output  3  {zero, carry, overflow}.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1; WEN=0.
  - RW, RX, RY = 0; busW = 0.
  - out_valid=0; out_data=0; out_flags=0.
- Reset has priority over every other event. Reset mid-operation abandons the instruction and no write occurs after that edge.
- Stored instruction: at acceptance, {op, rd, rs, rt} are latched into internal registers and held until the block returns to IDLE.
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
  - IDLE: in_ready=1. If in_valid=1, latch instr and go to READ; otherwise stay in IDLE.
  - READ, one cycle: RX=rs, RY=rt. Capture busX/busY into operand registers A/B at the end of the cycle. Go to EXEC.
  - EXEC, one cycle: compute result and flags into registers. Go to WRITE.
  - WRITE, one cycle: RW=rd, busW=result. WEN=1 only if rd!=0, because register 0 is read-only. Go to DONE.
  - DONE: out_valid=1, with out_data and out_flags stable. When out_ready=1, go to IDLE. The next instruction can be accepted no earlier than the following cycle.
- Outside READ, RX and RY hold their last values. Outside WRITE, WEN=0 and RW/busW hold their last values.
- in_ready=0 in every state except IDLE. in_valid is ignored while in_ready=0.
- Opcodes:
  - 0 ADD: A+B, 8-bit wrap. carry = bit 8 of the sum. overflow = signed overflow.
  - 1 SUB: A-B. carry = borrow (A<B unsigned). overflow = signed overflow.
  - 2 AND: A&B.
  - 3 OR: A|B.
  - 4 XOR: A^B.
  - 5 MOV: A.
  - 6 LI: {rs,rt} zero-extended to DW. Operands are read but ignored.
  - 7 SLT: 1 if A<B signed, else 0.
- Flags:
  - zero = (result==0) for every op.
  - carry and overflow = 0 for ops 2-7.
- Latency: instruction accepted at edge N. The write takes effect at edge N+3. out_valid=1 in the cycle following edge N+3.
- Back-to-back throughput is one instruction per 5 cycles when out_ready is held at 1.
- rs==rt, or rd==rs/rt, are legal. Operands are captured in READ, before the write.

Test Plan:
1. Reset, then preload r1=0x7F and r2=0x01 via LI. Then ADD rd=3, rs=1, rt=2 -> WEN pulses one cycle with RW=3 and busW=0x80. out_data=0x80, flags={0,0,1}.
2. SUB rd=4, rs=2, rt=1 with r2=0x01, r1=0x7F -> busW=0x82, flags={0,1,0}. SUB rd=5, rs=1, rt=1 -> 0x00, flags={1,0,0}.
3. MOV rd=0, rs=1 -> WEN stays 0 throughout; out_data=0x7F; a subsequent read of r0 returns 0x00.
4. Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data and out_flags are stable; in_ready=0; an in_valid pulse is ignored. Raising out_ready returns to IDLE.
5. Assert Rst_n=0 while in EXEC of an ADD to r6 -> no WEN pulse; r6 unchanged; in_ready=1 after the edge.
6. Random stream of 200 instructions against a reference model, with out_ready toggled randomly -> the register contents and every out_data/out_flags match the model. The WEN to out_valid spacing is exactly 1 cycle.
